// File: rtl/regfile_pkg.sv
// Shared constants, types and slice helper for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  // Low bit of field k in a bus of fields that are w bits wide each.
  function automatic int port_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: array/busy lookup, same-cycle write bypass, zero-register force.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int DEPTH    = 1 << ADDR_W
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] reg_array [DEPTH],
  input  logic [DEPTH-1:0]  busy_vec,
  input  logic              w0_en,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_val,
  input  logic              w1_en,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_val,
  input  logic              resv_en,
  input  logic [ADDR_W-1:0] resv_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  logic resv_hit;

  assign resv_hit = resv_en && (resv_addr == rd_addr);

  always_comb begin
    rd_data = reg_array[rd_addr];
    rd_busy = busy_vec[rd_addr];
    if (BYPASS != 0) begin
      // Port 1 is evaluated last so it takes priority over port 0.
      if (w0_en && (w0_addr == rd_addr)) begin
        rd_data = w0_val;
        rd_busy = resv_hit;
      end
      if (w1_en && (w1_addr == rd_addr)) begin
        rd_data = w1_val;
        rd_busy = resv_hit;
      end
    end
    if ((ZERO_REG != 0) && (rd_addr == '0)) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, optional bypass and a per-register busy scoreboard.
// No handshake: writes and reserves are accepted on every rising edge they are asserted.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_read,
  output logic [NUM_RD-1:0]        o_busy,
  input  logic                     i_RegWrite0,
  input  logic                     i_RegWrite1,
  input  logic [ADDR_W-1:0]        i_regW0_addr,
  input  logic [ADDR_W-1:0]        i_regW1_addr,
  input  logic [DATA_W-1:0]        i_regW0_val,
  input  logic [DATA_W-1:0]        i_regW1_val,
  input  logic                     i_Reserve,
  input  logic [ADDR_W-1:0]        i_resv_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic w0_en;
  logic w1_en;
  logic resv_en;

  // Qualified by reset so a write held during reset is neither stored nor forwarded.
  assign w0_en   = i_reset_n && i_RegWrite0 && !((ZERO_REG != 0) && (i_regW0_addr == '0));
  assign w1_en   = i_reset_n && i_RegWrite1 && !((ZERO_REG != 0) && (i_regW1_addr == '0));
  assign resv_en = i_reset_n && i_Reserve   && !((ZERO_REG != 0) && (i_resv_addr  == '0));

  // Later assignments win: port 1 over port 0, and a reserve over either write's busy clear.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (w0_en) begin
        regs[i_regW0_addr] <= i_regW0_val;
        busy[i_regW0_addr] <= 1'b0;
      end
      if (w1_en) begin
        regs[i_regW1_addr] <= i_regW1_val;
        busy[i_regW1_addr] <= 1'b0;
      end
      if (resv_en) begin
        busy[i_resv_addr] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS),
      .DEPTH    (DEPTH)
    ) u_rdport (
      .rd_addr   (i_rd_addr[port_lo(k, ADDR_W) +: ADDR_W]),
      .reg_array (regs),
      .busy_vec  (busy),
      .w0_en     (w0_en),
      .w0_addr   (i_regW0_addr),
      .w0_val    (i_regW0_val),
      .w1_en     (w1_en),
      .w1_addr   (i_regW1_addr),
      .w1_val    (i_regW1_val),
      .resv_en   (resv_en),
      .resv_addr (i_resv_addr),
      .rd_data   (o_read[port_lo(k, DATA_W) +: DATA_W]),
      .rd_busy   (o_busy[k])
    );
  end

endmodule
